// File: rtl/key_found_arbiter.sv
// key_found_arbiter: collects per-core "key found" pulses, round-robin
// arbitrates among pending cores, drives a one-hot result-mux select and
// hands the selected key to the consumer over a valid/ready handshake.
module key_found_arbiter #(
  parameter int unsigned N_CORES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [N_CORES-1:0] found,
  output logic [N_CORES-1:0] sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [CNT_W-1:0]   hits,
  output logic               overflow
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t               state;
  logic [N_CORES-1:0]   pending;
  logic [IDX_W-1:0]     rr_ptr;

  logic                 handshake;
  logic [N_CORES-1:0]   accept_mask;
  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic [N_CORES-1:0]   pick_onehot;
  logic [IDX_W-1:0]     next_rr;

  // Handshake decode; the accepted core's pending bit is masked so a
  // simultaneous re-arrival is a fresh event rather than an overflow.
  always_comb begin
    handshake   = (state == PRESENT) && out_valid && out_ready;
    accept_mask = handshake ? sel : '0;
    next_rr     = (grant_idx == IDX_W'(N_CORES - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Round-robin pick: first pending bit at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned j;
    j        = 0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= N_CORES) j = j - N_CORES;
      if (!pick_any && pending[j]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
    pick_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << pick_idx;
  end

  // Pending capture, overflow detection, grant FSM and hit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      grant_idx <= '0;
      hits      <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      pending   <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      grant_idx <= '0;
      hits      <= '0;
      overflow  <= 1'b0;
    end else begin
      pending <= (pending & ~accept_mask) | found;
      if (|(found & pending & ~accept_mask)) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pick_any) begin
            sel       <= pick_onehot;
            grant_idx <= pick_idx;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            sel       <= '0;
            grant_idx <= '0;
            out_valid <= 1'b0;
          end
        end
        PRESENT: begin
          if (handshake) begin
            rr_ptr    <= next_rr;
            if (hits != '1) hits <= hits + CNT_W'(1);
            sel       <= '0;
            grant_idx <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_found_arbiter.sv
// Scoreboard bench for key_found_arbiter: stimulus pushes the expected
// grant order, a negedge monitor pops and checks on every handshake.
module tb_key_found_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] found;
  logic [15:0] sel;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  grant_idx;
  logic [7:0]  hits;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  key_found_arbiter #(.N_CORES(16), .IDX_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .found     (found),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .hits      (hits),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one-hot/idle consistency every cycle, grant order on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("sel_onehot", 32'($countones(sel)), out_valid ? 32'd1 : 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(grant_idx), 32'hFFFF_FFFF);
        end else begin
          int e;
          logic [15:0] one;
          e   = exp_q.pop_front();
          one = 16'h0001;
          check("grant_idx", 32'(grant_idx), 32'(e));
          check("grant_sel", 32'(sel), 32'(one << e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] v);
    found = v;
    tick();
    found = '0;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    found     = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_hits", 32'(hits), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. async reset mid-PRESENT
    out_ready = 1'b1;
    exp_q.push_back(1);
    pulse(16'h0002);
    drain("t1_drain");
    check("t1_hits1", 32'(hits), 32'd1);
    out_ready = 1'b0;
    pulse(16'h0010);
    wait_valid("t1_valid");
    check("t1_sel_pre", 32'(sel), 32'h10);
    rst_n = 1'b0;
    #2;
    check("t1_async_sel", 32'(sel), 32'd0);
    check("t1_async_valid", 32'(out_valid), 32'd0);
    check("t1_async_hits", 32'(hits), 32'd0);
    check("t1_async_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 3. round-robin from rr_ptr=0: 0 then 15
    out_ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(15);
    pulse(16'h8001);
    drain("t3_drain");
    check("t3_hits", 32'(hits), 32'd2);

    // 2. single event with exact latency
    exp_q.push_back(5);
    pulse(16'h0020);
    check("t2_lat1_sel", 32'(sel), 32'd0);
    tick();
    check("t2_sel", 32'(sel), 32'h20);
    check("t2_idx", 32'(grant_idx), 32'd5);
    check("t2_valid", 32'(out_valid), 32'd1);
    tick();
    check("t2_after_sel", 32'(sel), 32'd0);
    check("t2_after_valid", 32'(out_valid), 32'd0);
    check("t2_hits", 32'(hits), 32'd3);

    // 4. backpressure on idx 3, idx 8 arrives while held
    out_ready = 1'b0;
    exp_q.push_back(3);
    pulse(16'h0008);
    wait_valid("t4_valid");
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t4_hold_sel", 32'(sel), 32'h0008);
    end
    exp_q.push_back(8);
    pulse(16'h0100);
    tick();
    check("t4_hold2_sel", 32'(sel), 32'h0008);
    check("t4_hold2_idx", 32'(grant_idx), 32'd3);
    out_ready = 1'b1;
    drain("t4_drain");
    check("t4_hits", 32'(hits), 32'd5);

    // clear drops a same-cycle found
    clear = 1'b1;
    found = 16'h0040;
    tick();
    clear = 1'b0;
    found = '0;
    check("clr_hits", 32'(hits), 32'd0);
    repeat (3) tick();
    check("clr_drop_valid", 32'(out_valid), 32'd0);

    // 5. re-arrival during handshake, then overflow
    out_ready = 1'b0;
    exp_q.push_back(2);
    pulse(16'h0004);
    wait_valid("t5_valid");
    out_ready = 1'b1;
    found     = 16'h0004;
    exp_q.push_back(2);
    tick();
    found     = '0;
    out_ready = 1'b0;
    check("t5_hs_ovf", 32'(overflow), 32'd0);
    check("t5_hs_valid", 32'(out_valid), 32'd0);
    tick();
    check("t5_regrant_valid", 32'(out_valid), 32'd1);
    check("t5_regrant_sel", 32'(sel), 32'h0004);
    check("t5_regrant_ovf", 32'(overflow), 32'd0);
    pulse(16'h0004);
    check("t5_ovf1", 32'(overflow), 32'd1);
    pulse(16'h0004);
    check("t5_ovf2", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    drain("t5_drain");
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6. saturation then clear
    for (int i = 0; i < 300; i++) begin
      logic [15:0] one;
      one = 16'h0001;
      exp_q.push_back(i % 16);
      pulse(one << (i % 16));
      repeat (2) tick();
    end
    drain("t6_drain");
    check("t6_hits_sat", 32'(hits), 32'hFF);
    check("t6_ovf_pre", 32'(overflow), 32'd1);
    clear = 1'b1;
    found = 16'h0001;
    tick();
    clear = 1'b0;
    found = '0;
    check("t6_clr_hits", 32'(hits), 32'd0);
    check("t6_clr_ovf", 32'(overflow), 32'd0);
    check("t6_clr_sel", 32'(sel), 32'd0);
    repeat (3) tick();
    check("t6_clr_pending", 32'(out_valid), 32'd0);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
